// File: rtl/mac_iter_unit_if.sv
// Handshake and operand bundle between the EX stage and the iterative multiply/MAC engine.
// EX drives the request side (master); the engine drives result, ready and busy (slave).
interface mac_iter_unit_if #(
  parameter int DATA_W = 32
);
  logic                  start_i;
  logic                  annul_i;
  logic [2:0]            op_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic [2*DATA_W-1:0]   hilo_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  busy_o;

  modport master (
    output start_i, annul_i, op_i, opdata1_i, opdata2_i, hilo_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  start_i, annul_i, op_i, opdata1_i, opdata2_i, hilo_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/mac_iter_unit.sv
// Iterative signed/unsigned MULT, MADD and MSUB engine retiring BPC multiplier bits per cycle.
// Signed operands are reduced to magnitudes; the sign is restored once before accumulation.
module mac_iter_unit #(
  parameter int DATA_W = 32,
  parameter int BPC    = 4
) (
  input  logic           clk,
  input  logic           rst,
  mac_iter_unit_if.slave bus
);
  localparam int ITER  = DATA_W / BPC;
  localparam int PW    = 2 * DATA_W;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e            state_r;
  state_e            next_state_s;
  logic [PW-1:0]     acc_r;
  logic [PW-1:0]     mcand_r;
  logic [DATA_W-1:0] mplier_r;
  logic [PW-1:0]     hilo_r;
  logic [PW-1:0]     result_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [1:0]        op_kind_r;
  logic              neg_r;
  logic              ready_r;
  logic              busy_r;

  logic              accept_s;
  logic              abort_s;
  logic              signed_op_s;
  logic [BPC-1:0]    digit_s;
  logic [PW-1:0]     pp_s;
  logic [PW-1:0]     prod_s;
  logic [PW-1:0]     final_s;

  // Op codes 110/111 fall back to MULTU, so they must not be treated as signed.
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op[0] == 1'b0) && (op[2:1] != 2'b11);
  endfunction

  // Most negative input maps to 2^(DATA_W-1), which still fits unsigned DATA_W bits.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic             sgn);
    if (sgn && v[DATA_W-1]) begin
      return ~v + DATA_W'(1'b1);
    end else begin
      return v;
    end
  endfunction

  assign accept_s    = bus.start_i & ~bus.annul_i;
  assign abort_s     = bus.annul_i | ~bus.start_i;
  assign signed_op_s = is_signed_op(bus.op_i);
  assign digit_s     = mplier_r[BPC-1:0];

  // Partial product and final {HI,LO} arithmetic, all modulo 2^PW.
  always_comb begin
    pp_s    = mcand_r * PW'(digit_s);
    prod_s  = acc_r;
    final_s = acc_r;
    if (neg_r) begin
      prod_s = ~acc_r + PW'(1'b1);
    end else begin
      prod_s = acc_r;
    end
    case (op_kind_r)
      2'b01:   final_s = hilo_r + prod_s;
      2'b10:   final_s = hilo_r - prod_s;
      default: final_s = prod_s;
    endcase
  end

  // Next-state logic; a dropped start outside IDLE behaves like an annul.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = ST_CALC;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (abort_s) begin
          next_state_s = ST_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          next_state_s = ST_ACC;
        end else begin
          next_state_s = ST_CALC;
        end
      end
      ST_ACC: begin
        if (abort_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      ST_DONE: begin
        if (abort_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Operand latch and shift-add datapath; mcand shifts left so no per-cycle barrel shift is needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r     <= '0;
      mcand_r   <= '0;
      mplier_r  <= '0;
      hilo_r    <= '0;
      cnt_r     <= '0;
      op_kind_r <= 2'b00;
      neg_r     <= 1'b0;
    end else if (state_r == ST_IDLE && accept_s) begin
      acc_r     <= '0;
      mcand_r   <= PW'(magnitude(bus.opdata1_i, signed_op_s));
      mplier_r  <= magnitude(bus.opdata2_i, signed_op_s);
      hilo_r    <= bus.hilo_i;
      cnt_r     <= '0;
      op_kind_r <= bus.op_i[2:1];
      neg_r     <= signed_op_s & (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
    end else if (state_r == ST_CALC) begin
      acc_r    <= acc_r + pp_s;
      mcand_r  <= mcand_r << BPC;
      mplier_r <= mplier_r >> BPC;
      cnt_r    <= cnt_r + CNT_W'(1'b1);
    end else begin
      acc_r <= acc_r;
    end
  end

  // Registered handshake outputs and result; result only changes on ACC -> DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_r  <= 1'b0;
      busy_r   <= 1'b0;
      result_r <= '0;
    end else begin
      ready_r <= (next_state_s == ST_DONE);
      busy_r  <= (next_state_s == ST_CALC) || (next_state_s == ST_ACC);
      if (state_r == ST_ACC && next_state_s == ST_DONE) begin
        result_r <= final_s;
      end else begin
        result_r <= result_r;
      end
    end
  end

  assign bus.result_o = result_r;
  assign bus.ready_o  = ready_r;
  assign bus.busy_o   = busy_r;
endmodule

// File: tb/tb_mac_iter_unit.sv
// Scoreboard bench for mac_iter_unit: directed and randomized ops on the default configuration
// plus latency/result checks on BPC=1, BPC=8 and DATA_W=16 instances.
module tb_mac_iter_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned cyc = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_iter_unit_if #(.DATA_W(32)) m_if ();
  mac_iter_unit_if #(.DATA_W(32)) s1_if ();
  mac_iter_unit_if #(.DATA_W(32)) s8_if ();
  mac_iter_unit_if #(.DATA_W(16)) s16_if ();

  mac_iter_unit #(.DATA_W(32), .BPC(4)) dut     (.clk(clk), .rst(rst), .bus(m_if));
  mac_iter_unit #(.DATA_W(32), .BPC(1)) u_bpc1  (.clk(clk), .rst(rst), .bus(s1_if));
  mac_iter_unit #(.DATA_W(32), .BPC(8)) u_bpc8  (.clk(clk), .rst(rst), .bus(s8_if));
  mac_iter_unit #(.DATA_W(16), .BPC(4)) u_w16   (.clk(clk), .rst(rst), .bus(s16_if));

  typedef struct {
    logic [63:0] res;
    int unsigned rdy_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic ready_q = 1'b0;
  logic [63:0] last_res = 64'h0;

  // Reference: full-precision signed/unsigned product, then accumulate modulo 2^64.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] hilo);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] prod;
    if (op == 3'd0 || op == 3'd2 || op == 3'd4) begin
      sa = $signed(a);
      sb = $signed(b);
      prod = sa * sb;
    end else begin
      ua = a;
      ub = b;
      prod = ua * ub;
    end
    case (op)
      3'd2, 3'd3: return hilo + prod;
      3'd4, 3'd5: return hilo - prod;
      default:    return prod;
    endcase
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: every rising ready_o must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst && m_if.ready_o && !ready_q) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ready: ready_o rose at cycle %0d with nothing pending", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("result", m_if.result_o, mon_e.res);
        check("latency", 64'(cyc), 64'(mon_e.rdy_cyc));
      end
    end
    ready_q <= m_if.ready_o;
  end

  // Called just after a negedge. Operands are scrambled after acceptance to prove they are latched.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] hilo, input logic [63:0] expv, input int hold);
    int busy_cnt;
    bit seen;
    m_if.op_i      = op;
    m_if.opdata1_i = a;
    m_if.opdata2_i = b;
    m_if.hilo_i    = hilo;
    m_if.annul_i   = 1'b0;
    m_if.start_i   = 1'b1;
    sb_q.push_back('{expv, cyc + 10});
    busy_cnt = 0;
    seen = 1'b0;
    for (int w = 0; w < 60 && !seen; w++) begin
      @(negedge clk);
      m_if.opdata1_i = $urandom;
      m_if.opdata2_i = $urandom;
      m_if.hilo_i    = {$urandom, $urandom};
      if (m_if.busy_o) busy_cnt++;
      if (m_if.ready_o) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: ready_o not seen within 60 cycles, want cycle 10");
      sb_q.delete();
    end
    check("busy_cycles", 64'(busy_cnt), 64'd9);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_ready", 64'(m_if.ready_o), 64'd1);
      check("hold_result", m_if.result_o, expv);
    end
    m_if.start_i = 1'b0;
    @(negedge clk);
    check("drop_ready", 64'(m_if.ready_o), 64'd0);
    check("drop_busy", 64'(m_if.busy_o), 64'd0);
    check("keep_result", m_if.result_o, expv);
    last_res = expv;
  endtask

  task automatic annul_test();
    int rises;
    m_if.op_i      = 3'd1;
    m_if.opdata1_i = 32'h1234_5678;
    m_if.opdata2_i = 32'h0000_0101;
    m_if.annul_i   = 1'b0;
    m_if.start_i   = 1'b1;
    repeat (4) @(negedge clk);
    m_if.annul_i = 1'b1;
    m_if.start_i = 1'b0;
    @(negedge clk);
    m_if.annul_i = 1'b0;
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_if.ready_o) rises++;
    end
    check("annul_no_ready", 64'(rises), 64'd0);
    check("annul_busy", 64'(m_if.busy_o), 64'd0);
    check("annul_result", m_if.result_o, last_res);
  endtask

  task automatic idle_annul_test();
    int busy_seen;
    m_if.op_i      = 3'd0;
    m_if.opdata1_i = 32'd9;
    m_if.opdata2_i = 32'd9;
    m_if.start_i   = 1'b1;
    m_if.annul_i   = 1'b1;
    busy_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (m_if.busy_o || m_if.ready_o) busy_seen++;
    end
    check("idle_annul_blocks", 64'(busy_seen), 64'd0);
  endtask

  task automatic reset_test();
    m_if.op_i      = 3'd0;
    m_if.opdata1_i = 32'd1000;
    m_if.opdata2_i = 32'd3;
    m_if.annul_i   = 1'b0;
    m_if.start_i   = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_ready", 64'(m_if.ready_o), 64'd0);
    check("async_rst_busy", 64'(m_if.busy_o), 64'd0);
    check("async_rst_result", m_if.result_o, 64'd0);
    sb_q.delete();
    m_if.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_busy", 64'(m_if.busy_o), 64'd0);
    last_res = 64'd0;
  endtask

  task automatic sweep_test();
    logic [31:0] a1, b1, a8, b8;
    logic [63:0] h1, h8, e1, e8;
    int r1, r8, r16;
    a1 = $urandom; b1 = $urandom; h1 = {$urandom, $urandom};
    a8 = $urandom; b8 = $urandom; h8 = {$urandom, $urandom};
    e1 = ref_model(3'd2, a1, b1, h1);
    e8 = ref_model(3'd5, a8, b8, h8);
    s1_if.op_i = 3'd2;  s1_if.opdata1_i = a1; s1_if.opdata2_i = b1; s1_if.hilo_i = h1;
    s8_if.op_i = 3'd5;  s8_if.opdata1_i = a8; s8_if.opdata2_i = b8; s8_if.hilo_i = h8;
    s16_if.op_i = 3'd0; s16_if.opdata1_i = 16'h8000; s16_if.opdata2_i = 16'hFFFF;
    s16_if.hilo_i = 32'h0;
    s1_if.start_i = 1'b1; s8_if.start_i = 1'b1; s16_if.start_i = 1'b1;
    r1 = 0; r8 = 0; r16 = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (s1_if.ready_o && r1 == 0) begin
        r1 = k;
        check("bpc1_result", s1_if.result_o, e1);
      end
      if (s8_if.ready_o && r8 == 0) begin
        r8 = k;
        check("bpc8_result", s8_if.result_o, e8);
      end
      if (s16_if.ready_o && r16 == 0) begin
        r16 = k;
        check("w16_result", 64'(s16_if.result_o), 64'h0000_8000);
      end
    end
    check("bpc1_latency", 64'(r1), 64'd34);
    check("bpc8_latency", 64'(r8), 64'd6);
    check("w16_latency", 64'(r16), 64'd6);
    s1_if.start_i = 1'b0; s8_if.start_i = 1'b0; s16_if.start_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] h;
    m_if.start_i = 1'b0;   m_if.annul_i = 1'b0;   m_if.op_i = 3'd0;
    m_if.opdata1_i = '0;   m_if.opdata2_i = '0;   m_if.hilo_i = '0;
    s1_if.start_i = 1'b0;  s1_if.annul_i = 1'b0;  s1_if.op_i = 3'd0;
    s1_if.opdata1_i = '0;  s1_if.opdata2_i = '0;  s1_if.hilo_i = '0;
    s8_if.start_i = 1'b0;  s8_if.annul_i = 1'b0;  s8_if.op_i = 3'd0;
    s8_if.opdata1_i = '0;  s8_if.opdata2_i = '0;  s8_if.hilo_i = '0;
    s16_if.start_i = 1'b0; s16_if.annul_i = 1'b0; s16_if.op_i = 3'd0;
    s16_if.opdata1_i = '0; s16_if.opdata2_i = '0; s16_if.hilo_i = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(m_if.ready_o), 64'd0);
    check("rst_busy", 64'(m_if.busy_o), 64'd0);
    check("rst_result", m_if.result_o, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    do_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    reset_test();
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 64'hFFFF_FFFE_0000_0001, 3);
    do_op(3'd0, 32'h8000_0000, 32'h8000_0000, 64'h0, 64'h4000_0000_0000_0000, 1);
    do_op(3'd2, 32'd3, 32'd5, 64'h10, 64'h0000_0000_0000_001F, 0);
    do_op(3'd5, 32'd3, 32'd5, 64'h10, 64'h0000_0000_0000_0001, 0);
    do_op(3'd4, 32'hFFFF_FFFF, 32'd1, 64'h10, 64'h0000_0000_0000_0011, 0);
    do_op(3'd3, 32'd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0);
    annul_test();
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 64'h0, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    idle_annul_test();
    do_op(3'd6, 32'h0001_0000, 32'h0001_0000, 64'h5, 64'h0000_0001_0000_0000, 0);

    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = rnd_opnd();
      b  = rnd_opnd();
      h  = {$urandom, $urandom};
      do_op(op, a, b, h, ref_model(op, a, b, h), $urandom_range(0, 3));
    end

    sweep_test();
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mac_iter_unit.md
Name: mac_iter_unit

Overview:
- Parametrised iterative multiply / multiply-accumulate unit for the EX stage.
- Replaces the combinational multiplier and the two-cycle cnt/hilo_temp MADD/MSUB sequencing with one multi-cycle engine.
- Uses a start/ready handshake modelled on the divider interface: EX holds start_i and stalls until ready_o.
- Supports signed/unsigned MULT, MADD and MSUB at configurable width and radix.

Parameters:
- DATA_W, 32: operand width; HI/LO and result are 2*DATA_W.
- BPC, 4: multiplier bits retired per cycle; must divide DATA_W (1, 2, 4, 8, ...).
- Derived ITER = DATA_W/BPC: number of CALC cycles.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; 0 forces reset state immediately.
- start_i  in  1  operation request; held high by EX until ready_o is seen.
- annul_i  in  1  cancel (flush/exception); aborts any operation in flight.
- op_i  in  3  000 MULT, 001 MULTU, 010 MADD, 011 MADDU, 100 MSUB, 101 MSUBU; 110/111 treated as MULTU.
- opdata1_i  in  DATA_W  multiplicand (rs).
- opdata2_i  in  DATA_W  multiplier (rt).
- hilo_i  in  2*DATA_W  forwarded {HI,LO} accumulator operand.
- result_o  out  2*DATA_W  final {HI,LO} value.
- ready_o  out  1  result valid.
- busy_o  out  1  high in CALC or ACC.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - result_o=0, ready_o=0, busy_o=0.
  - All internal registers (acc, cnt, latched operands) = 0.
- States: IDLE, CALC, ACC, DONE. All outputs are registered.
- IDLE, on start_i=1 and annul_i=0:
  - Signed ops (op_i[0]=0): latch |opdata1_i| and |opdata2_i| as unsigned DATA_W values.
    - -2^(DATA_W-1) gives magnitude 2^(DATA_W-1); no overflow.
  - Unsigned ops: latch opdata1_i and opdata2_i as-is.
  - Latch neg = signed & (op1[MSB]^op2[MSB]).
  - Latch op_i and hilo_i; hilo_i is sampled only at this edge.
  - acc=0, cnt=0; go to CALC.
- CALC, each cycle:
  - acc += (mcand * mplier[BPC-1:0]) << (cnt*BPC); mplier >>= BPC; cnt++.
  - After ITER iterations go to ACC.
- ACC:
  - prod = neg ? -acc : acc (2*DATA_W, two's complement).
  - MULT/MULTU: result_o = prod.
  - MADD/MADDU: result_o = hilo + prod.
  - MSUB/MSUBU: result_o = hilo - prod.
  - All arithmetic modulo 2^(2*DATA_W); no overflow flag.
  - Go to DONE with ready_o=1.
- DONE:
  - ready_o=1 and result_o stable while start_i=1.
  - When start_i=0: ready_o=0, go to IDLE; result_o keeps its last value.
- Latency: start_i sampled high in cycle 0 -> ready_o high in cycle ITER+2 (cycle 10 for the defaults).
- Annul:
  - annul_i=1 in CALC, ACC or DONE -> IDLE at next edge; ready_o=0; result_o unchanged.
  - annul_i=1 in IDLE blocks acceptance, even if start_i=1.
- Simultaneous start_i=1 and annul_i=1: annul wins; no operation starts.
- start_i dropping in CALC/ACC: treated as annul.
- Operand changes after acceptance are ignored; the operation uses latched values only.
- Back-to-back: a new start_i is accepted only from IDLE, so there is at least one idle cycle between operations.

Test Plan:
- Reset mid-CALC: pull rst low asynchronously -> ready_o, busy_o and result_o go to 0 without a clock edge; after release, state is IDLE.
- MULT, 0xFFFFFFFF x 0x00000002 (-1 x 2):
  - ready_o high in cycle 10.
  - result_o = 0xFFFFFFFF_FFFFFFFE.
  - busy_o high in cycles 1..9.
- MULTU, 0xFFFFFFFF x 0xFFFFFFFF -> result_o = 0xFFFFFFFE_00000001.
- MULT, 0x80000000 x 0x80000000 -> result_o = 0x40000000_00000000.
- Accumulate with hilo_i = 0x00000000_00000010:
  - MADD 3 x 5 -> 0x00000000_0000001F.
  - MSUBU 3 x 5 -> 0x00000000_00000001.
  - MSUB 0xFFFFFFFF x 1 (-1 x 1) -> 0x00000000_00000011.
  - MADDU with hilo_i = 0xFFFFFFFF_FFFFFFFF, 1 x 1 -> 0x00000000_00000000 (wrap).
- Annul: pulse annul_i in cycle 4 of an operation -> ready_o never rises; next start_i gives a correct result.
- Handshake: hold start_i 3 cycles past ready_o -> ready_o and result_o stay stable; drop start_i -> ready_o=0 next cycle.
- Parameter sweep:
  - BPC=1 -> ready_o in cycle 34.
  - BPC=8 -> ready_o in cycle 6.
  - DATA_W=16, BPC=4: MULT 0x8000 x 0xFFFF -> 0x00008000.
